// File: rtl/counter_arb_pkg.sv
// Shared types and constants for the counter arbitration controller.
// Build option: COUNTER_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
package counter_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Cycles the counter needs, after its enable drops, to return to idle.
  localparam int DRAIN_CYCLES = 2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_arb_ctrl_if.sv
// Requester and counter-side signal bundle for counter_arb_ctrl.
// Build option: COUNTER_ARB_FIXED_PRIO_EN (affects the controller only).
//
// Handshake: req[i] is a level request. The controller acknowledges by
// raising grant[i] (one-hot) and captures the operands in that same cycle;
// grant stays high until the cycle after the one-cycle done pulse. Later
// changes to req or operands do not affect the granted job.
interface counter_arb_ctrl_if #(
  parameter int NUM_REQ       = 4,
  parameter int COUNTER_WIDTH = 16,
  parameter int STEP_WIDTH    = 8
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ-1:0]               req_dir;
  logic [NUM_REQ*COUNTER_WIDTH-1:0] req_load_value;
  logic [NUM_REQ*STEP_WIDTH-1:0]    req_steps;
  logic [NUM_REQ-1:0]               grant;
  logic                             busy;
  logic                             done;
  logic [IDX_W-1:0]                 done_id;
  logic [COUNTER_WIDTH-1:0]         done_value;
  logic                             done_wrap;
  logic                             ctr_load_enable;
  logic [COUNTER_WIDTH-1:0]         ctr_load_value;
  logic                             ctr_count_enable;
  logic                             ctr_count_direction;
  logic [COUNTER_WIDTH-1:0]         ctr_value;
  logic                             ctr_overflow;
  logic                             ctr_underflow;

  // Requesters plus the counter instance.
  modport master (
    output req, req_dir, req_load_value, req_steps,
    output ctr_value, ctr_overflow, ctr_underflow,
    input  grant, busy, done, done_id, done_value, done_wrap,
    input  ctr_load_enable, ctr_load_value, ctr_count_enable, ctr_count_direction
  );

  // The controller.
  modport slave (
    input  req, req_dir, req_load_value, req_steps,
    input  ctr_value, ctr_overflow, ctr_underflow,
    output grant, busy, done, done_id, done_value, done_wrap,
    output ctr_load_enable, ctr_load_value, ctr_count_enable, ctr_count_direction
  );

endinterface

// File: rtl/counter_arb_rr_picker.sv
// Combinational one-hot request picker with index output.
// Build option: COUNTER_ARB_FIXED_PRIO_EN removes the pointer and makes the
// lowest asserted index win; otherwise the search starts at i_ptr and wraps.
module counter_arb_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
`ifndef COUNTER_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   i_ptr,
`endif
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  // Walk the requests in priority order and keep the first one found.
  always_comb begin
    int w_j;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef COUNTER_ARB_FIXED_PRIO_EN
      w_j = i;
`else
      w_j = (int'(i_ptr) + i) % NUM_REQ;
`endif
      if (!o_valid && i_req[w_j]) begin
        o_valid      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = IDX_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/counter_arb_ctrl.sv
// Scheduler that time-shares one up/down counter among NUM_REQ requesters.
// Build option: COUNTER_ARB_FIXED_PRIO_EN selects fixed-priority arbitration
// (no round-robin pointer); default is round-robin.
module counter_arb_ctrl
  import counter_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int COUNTER_WIDTH = 16,
  parameter int STEP_WIDTH    = 8
) (
  input  logic                clk,
  input  logic                rst,
  counter_arb_ctrl_if.slave   bus,
  output state_e              o_dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = STEP_WIDTH + 1;

  state_e                   r_state;
  logic [NUM_REQ-1:0]       r_grant;
  logic                     r_busy;
  logic [IDX_W-1:0]         r_id;
  logic                     r_cap_dir;
  logic [CNT_W-1:0]         r_cnt;
  logic [1:0]               r_drain;
  logic                     r_wrap;
  logic                     r_done;
  logic [IDX_W-1:0]         r_done_id;
  logic [COUNTER_WIDTH-1:0] r_done_value;
  logic                     r_done_wrap;
  logic                     r_ld_en;
  logic [COUNTER_WIDTH-1:0] r_ld_val;
  logic                     r_cnt_en;
  logic                     r_ctr_dir;

  logic [NUM_REQ-1:0]       w_grant;
  logic [IDX_W-1:0]         w_idx;
  logic                     w_valid;

`ifndef COUNTER_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]         r_ptr;
`endif

  counter_arb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req   (bus.req),
`ifndef COUNTER_ARB_FIXED_PRIO_EN
    .i_ptr   (r_ptr),
`endif
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

`ifndef COUNTER_ARB_FIXED_PRIO_EN
  // Pointer moves past each winner so every requester gets a turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (r_state == ST_IDLE && w_valid) begin
      r_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end
`endif

  // Job sequencer: arbitrate, load, count, drain, report.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_id         <= '0;
      r_cap_dir    <= DIR_UP;
      r_cnt        <= '0;
      r_drain      <= '0;
      r_wrap       <= 1'b0;
      r_done       <= 1'b0;
      r_done_id    <= '0;
      r_done_value <= '0;
      r_done_wrap  <= 1'b0;
      r_ld_en      <= 1'b0;
      r_ld_val     <= '0;
      r_cnt_en     <= 1'b0;
      r_ctr_dir    <= DIR_UP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_grant   <= w_grant;
            r_busy    <= 1'b1;
            r_id      <= w_idx;
            r_cap_dir <= bus.req_dir[w_idx];
            // Hold steps+1: the first enabled cycle only starts the counter.
            r_cnt     <= {1'b0, bus.req_steps[w_idx*STEP_WIDTH +: STEP_WIDTH]} + CNT_W'(1);
            r_wrap    <= 1'b0;
            r_ld_en   <= 1'b1;
            r_ld_val  <= bus.req_load_value[w_idx*COUNTER_WIDTH +: COUNTER_WIDTH];
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_ld_en  <= 1'b0;
          r_ld_val <= '0;
          if (r_cnt == CNT_W'(1)) begin
            r_drain <= 2'(DRAIN_CYCLES - 1);
            r_state <= ST_DRAIN;
          end else begin
            r_cnt_en  <= 1'b1;
            r_ctr_dir <= r_cap_dir;
            r_state   <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (bus.ctr_overflow || bus.ctr_underflow || r_cnt == CNT_W'(1)) begin
            r_wrap    <= bus.ctr_overflow | bus.ctr_underflow;
            r_cnt_en  <= 1'b0;
            r_ctr_dir <= DIR_UP;
            r_drain   <= 2'(DRAIN_CYCLES - 1);
            r_state   <= ST_DRAIN;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (r_drain == '0) begin
            r_done       <= 1'b1;
            r_done_id    <= r_id;
            r_done_value <= bus.ctr_value;
            r_done_wrap  <= r_wrap;
            r_state      <= ST_DONE;
          end else begin
            r_drain <= r_drain - 2'd1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant               = r_grant;
  assign bus.busy                = r_busy;
  assign bus.done                = r_done;
  assign bus.done_id             = r_done_id;
  assign bus.done_value          = r_done_value;
  assign bus.done_wrap           = r_done_wrap;
  assign bus.ctr_load_enable     = r_ld_en;
  assign bus.ctr_load_value      = r_ld_val;
  assign bus.ctr_count_enable    = r_cnt_en;
  assign bus.ctr_count_direction = r_ctr_dir;
  assign o_dbg_state             = r_state;

endmodule

// File: tb/tb_counter_arb_ctrl.sv
// Directed bench for counter_arb_ctrl with a behavioural counter attached.
// Build option: COUNTER_ARB_FIXED_PRIO_EN changes the expected grant order.
module tb_counter_arb_ctrl;
  import counter_arb_pkg::*;

  localparam int NR = 4;
  localparam int CW = 16;
  localparam int SW = 8;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     checks;
  int     errors;

  counter_arb_ctrl_if #(.NUM_REQ(NR), .COUNTER_WIDTH(CW), .STEP_WIDTH(SW)) bus ();

  counter_arb_ctrl #(.NUM_REQ(NR), .COUNTER_WIDTH(CW), .STEP_WIDTH(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: load, one start-up cycle, then +/-1 per enabled cycle.
  // On a wrap it raises a one-cycle flag and holds until enable drops.
  logic m_cnting;
  logic m_halt;
  always @(posedge clk) begin
    if (rst) begin
      bus.ctr_value     <= '0;
      bus.ctr_overflow  <= 1'b0;
      bus.ctr_underflow <= 1'b0;
      m_cnting          <= 1'b0;
      m_halt            <= 1'b0;
    end else begin
      bus.ctr_overflow  <= 1'b0;
      bus.ctr_underflow <= 1'b0;
      if (bus.ctr_load_enable) begin
        bus.ctr_value <= bus.ctr_load_value;
        m_cnting      <= 1'b0;
        m_halt        <= 1'b0;
      end else if (bus.ctr_count_enable) begin
        if (m_halt) begin
          m_halt <= 1'b1;
        end else if (!m_cnting) begin
          m_cnting <= 1'b1;
        end else if (bus.ctr_count_direction == DIR_UP) begin
          bus.ctr_value <= bus.ctr_value + 16'd1;
          if (bus.ctr_value == 16'hFFFF) begin
            bus.ctr_overflow <= 1'b1;
            m_halt           <= 1'b1;
          end
        end else begin
          bus.ctr_value <= bus.ctr_value - 16'd1;
          if (bus.ctr_value == 16'h0000) begin
            bus.ctr_underflow <= 1'b1;
            m_halt            <= 1'b1;
          end
        end
      end else begin
        m_cnting <= 1'b0;
        m_halt   <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},  32'(bus.grant), 0);
    check({tag, "_busy"},   32'(bus.busy), 0);
    check({tag, "_done"},   32'(bus.done), 0);
    check({tag, "_id"},     32'(bus.done_id), 0);
    check({tag, "_dval"},   32'(bus.done_value), 0);
    check({tag, "_dwrap"},  32'(bus.done_wrap), 0);
    check({tag, "_ld_en"},  32'(bus.ctr_load_enable), 0);
    check({tag, "_ld_val"}, 32'(bus.ctr_load_value), 0);
    check({tag, "_cnt_en"}, 32'(bus.ctr_count_enable), 0);
    check({tag, "_dir"},    32'(bus.ctr_count_direction), 0);
    check({tag, "_state"},  32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Driver: one request, then scramble its operands to prove they were captured.
  task automatic do_job(input string tag, input int idx, input logic dir,
                        input logic [15:0] val, input logic [7:0] steps,
                        input int exp_edge, input logic [15:0] exp_val,
                        input logic exp_wrap, input int exp_en);
    int e;
    int en_n;
    int got_edge;
    logic got;
    logic [15:0] got_val;
    logic got_wrap;
    logic [1:0] got_id;
    @(negedge clk);
    bus.req                     = '0;
    bus.req[idx]                = 1'b1;
    bus.req_dir[idx]            = dir;
    bus.req_load_value[idx*CW +: CW] = val;
    bus.req_steps[idx*SW +: SW] = steps;
    @(posedge clk); #1;
    check({tag, "_grant0"}, 32'(bus.grant), 32'(1) << idx);
    check({tag, "_busy0"},  32'(bus.busy), 1);
    check({tag, "_ld_en0"}, 32'(bus.ctr_load_enable), 1);
    check({tag, "_ld_val0"}, 32'(bus.ctr_load_value), 32'(val));
    bus.req                     = '0;
    bus.req_dir[idx]            = ~dir;
    bus.req_load_value[idx*CW +: CW] = ~val;
    bus.req_steps[idx*SW +: SW] = steps + 8'd7;
    e = 0; en_n = 0; got = 1'b0; got_edge = -1;
    got_val = '0; got_wrap = 1'b0; got_id = '0;
    while (!got && e < 400) begin
      @(posedge clk); #1;
      e++;
      if (bus.ctr_count_enable) en_n++;
      if (bus.done) begin
        got      = 1'b1;
        got_edge = e;
        got_val  = bus.done_value;
        got_wrap = bus.done_wrap;
        got_id   = bus.done_id;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 1);
    check({tag, "_done_edge"}, 32'(got_edge), 32'(exp_edge));
    check({tag, "_done_value"}, 32'(got_val), 32'(exp_val));
    check({tag, "_done_wrap"}, 32'(got_wrap), 32'(exp_wrap));
    check({tag, "_done_id"}, 32'(got_id), 32'(idx));
    check({tag, "_en_cycles"}, 32'(en_n), 32'(exp_en));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 0);
    check({tag, "_grant_clr"}, 32'(bus.grant), 0);
    check({tag, "_busy_clr"}, 32'(bus.busy), 0);
  endtask

  initial begin
    int exp_ids[5];
    logic [15:0] rr_vals[4];
    int ec;
    int last;
    int k;
    logic seen;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.req_dir = '0;
    bus.req_load_value = '0;
    bus.req_steps = '0;

`ifdef COUNTER_ARB_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 2, 3, 0};
`endif
    rr_vals = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Round-robin: all four requesting, steps = 1, up.
    for (int i = 0; i < NR; i++) begin
      bus.req_load_value[i*CW +: CW] = rr_vals[i];
      bus.req_steps[i*SW +: SW]      = 8'd1;
      bus.req_dir[i]                 = DIR_UP;
    end
    bus.req = 4'b1111;
    ec = 0; last = -1; k = 0;
    while (k < 5 && ec < 300) begin
      @(posedge clk); #1;
      ec++;
      if (bus.done) begin
        check($sformatf("rr_id%0d", k), 32'(bus.done_id), 32'(exp_ids[k]));
        check($sformatf("rr_val%0d", k), 32'(bus.done_value),
              32'(rr_vals[exp_ids[k]] + 16'd1));
        if (k > 0) check($sformatf("rr_gap%0d", k), 32'(ec - last), 7);
        last = ec;
        k++;
        if (k == 5) bus.req = '0;
      end
    end
    check("rr_jobs", 32'(k), 5);
    repeat (4) @(posedge clk);
    #1;
    check("rr_idle_busy", 32'(bus.busy), 0);

    // Single job: 100 up 5 steps.
    do_job("single", 0, DIR_UP, 16'd100, 8'd5, 9, 16'd105, 1'b0, 6);
    // Up-wrap: counter wraps at edge 4, enable drops at 5, done at 7.
    do_job("upwrap", 1, DIR_UP, 16'hFFFE, 8'd5, 7, 16'h0000, 1'b1, 4);
    // Down-wrap: 1 -> 0 -> FFFF at edge 4.
    do_job("dnwrap", 3, DIR_DOWN, 16'h0001, 8'd3, 7, 16'hFFFF, 1'b1, 4);
    // Zero steps: straight from load to drain.
    do_job("zero", 2, DIR_UP, 16'h1234, 8'd0, 3, 16'h1234, 1'b0, 0);
    // Long down job with no wrap.
    do_job("down", 1, DIR_DOWN, 16'h0100, 8'd16, 20, 16'h00F0, 1'b0, 17);

    // Reset at edge 4 of a 10-step job.
    @(negedge clk);
    bus.req = 4'b0001;
    bus.req_load_value[0 +: CW] = 16'd5;
    bus.req_steps[0 +: SW] = 8'd10;
    bus.req_dir[0] = DIR_UP;
    @(posedge clk); #1;
    check("rstmid_busy0", 32'(bus.busy), 1);
    repeat (3) @(posedge clk);
    #1;
    check("rstmid_cnt_en3", 32'(bus.ctr_count_enable), 1);
    rst = 1'b1;
    bus.req = '0;
    @(posedge clk); #1;
    check_all_zero("rstmid");
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("rstmid_no_done", 32'(seen), 0);
    do_job("after_rst", 2, DIR_DOWN, 16'd7, 8'd2, 6, 16'd5, 1'b0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
